// File: rtl/gelato_split_table_rr.sv
// Per-warp divergence table: holds (pc, mask) split entries and issues READY ones round-robin.
// Optional feature: define SPLIT_TABLE_MERGE_EN to OR-merge READY entries that share a pc.
module gelato_split_table_rr #(
   parameter  int unsigned ENTRY_NUM  = 4,
   parameter  int unsigned THREAD_NUM = 32,
   parameter  int unsigned PC_WIDTH   = 32,
   localparam int unsigned IDX_W      = $clog2(ENTRY_NUM)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdy,
   input  logic                  init_valid,
   input  logic [PC_WIDTH-1:0]   init_pc,
   output logic                  sel_valid,
   input  logic                  sel_ready,
   output logic [IDX_W-1:0]      sel_idx,
   output logic [PC_WIDTH-1:0]   sel_pc,
   output logic [THREAD_NUM-1:0] sel_mask,
   input  logic                  upd_valid,
   input  logic [IDX_W-1:0]      upd_idx,
   input  logic [PC_WIDTH-1:0]   upd_pc,
   input  logic                  upd_stall,
   input  logic                  upd_exit,
   input  logic                  upd_split,
   input  logic [THREAD_NUM-1:0] upd_taken_mask,
   input  logic [PC_WIDTH-1:0]   upd_taken_pc,
   output logic                  split_ready,
   input  logic                  wake_valid,
   input  logic [IDX_W-1:0]      wake_idx,
   output logic                  empty
);

   typedef enum logic [1:0] {ST_FREE, ST_READY, ST_ISSUED, ST_PARKED} st_e;

   st_e                   r_st   [ENTRY_NUM];
   logic [PC_WIDTH-1:0]   r_pc   [ENTRY_NUM];
   logic [THREAD_NUM-1:0] r_mask [ENTRY_NUM];
   logic [IDX_W-1:0]      r_rr;
   logic                  r_sel_valid;
   logic [IDX_W-1:0]      r_sel_idx;
   logic [PC_WIDTH-1:0]   r_sel_pc;
   logic [THREAD_NUM-1:0] r_sel_mask;
   logic                  r_split_ready;
   logic                  r_empty;

   st_e                   w_st   [ENTRY_NUM];
   logic [PC_WIDTH-1:0]   w_pc   [ENTRY_NUM];
   logic [THREAD_NUM-1:0] w_mask [ENTRY_NUM];
   logic [IDX_W-1:0]      w_rr;
   logic                  w_sel_valid;
   logic [IDX_W-1:0]      w_sel_idx;
   logic [PC_WIDTH-1:0]   w_sel_pc;
   logic [THREAD_NUM-1:0] w_sel_mask;
   logic                  w_split_ready;
   logic                  w_empty;

   logic                  w_all_free;
   logic                  w_free_found;
   logic [IDX_W-1:0]      w_free_idx;
   logic                  w_pick_found;
   logic [IDX_W-1:0]      w_pick_idx;
   logic [IDX_W-1:0]      w_cand;
   logic                  w_sel_fire;
   logic                  w_upd_ok;
   logic [THREAD_NUM-1:0] w_tk;
   logic [THREAD_NUM-1:0] w_rem;
   logic                  w_alloc;
`ifdef SPLIT_TABLE_MERGE_EN
   logic [ENTRY_NUM-1:0]  w_excl;
   logic                  w_merged;
`endif

   assign w_sel_fire = !r_sel_valid || sel_ready;
   assign w_upd_ok   = upd_valid && (r_st[upd_idx] == ST_ISSUED);
   assign w_tk       = r_mask[upd_idx] & upd_taken_mask;
   assign w_rem      = r_mask[upd_idx] & ~upd_taken_mask;
   assign w_alloc    = w_upd_ok && !upd_exit && upd_split && (w_tk != '0) && (w_rem != '0);

   // Next-state: init, wake, update, select (and optional merge), then status flags.
   always_comb begin
      w_st          = r_st;
      w_pc          = r_pc;
      w_mask        = r_mask;
      w_rr          = r_rr;
      w_sel_valid   = r_sel_valid;
      w_sel_idx     = r_sel_idx;
      w_sel_pc      = r_sel_pc;
      w_sel_mask    = r_sel_mask;
      w_all_free    = 1'b1;
      w_free_found  = 1'b0;
      w_free_idx    = '0;
      w_pick_found  = 1'b0;
      w_pick_idx    = '0;
      w_cand        = '0;
      w_split_ready = 1'b0;
      w_empty       = 1'b1;
`ifdef SPLIT_TABLE_MERGE_EN
      w_excl        = '0;
      w_merged      = 1'b0;
`endif

      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
         if (r_st[i] == ST_FREE) begin
            if (!w_free_found) begin
               w_free_found = 1'b1;
               w_free_idx   = IDX_W'(i);
            end
         end else begin
            w_all_free = 1'b0;
         end
      end

      // Round-robin scan starts one past the last issued entry.
      for (int unsigned k = 1; k <= ENTRY_NUM; k++) begin
         w_cand = r_rr + IDX_W'(k);
         if (!w_pick_found && (r_st[w_cand] == ST_READY)) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand;
         end
      end

      if (rdy) begin
         if (init_valid && w_all_free) begin
            w_st[0]   = ST_READY;
            w_pc[0]   = init_pc;
            w_mask[0] = '1;
         end

         if (wake_valid && (r_st[wake_idx] == ST_PARKED))
            w_st[wake_idx] = ST_READY;

         if (w_upd_ok) begin
            if (upd_exit) begin
               w_st[upd_idx] = ST_FREE;
            end else if (upd_split && (w_tk != '0)) begin
               w_st[upd_idx] = ST_READY;
               if (w_rem == '0) begin
                  w_pc[upd_idx] = upd_taken_pc;
               end else begin
                  w_pc[upd_idx]   = upd_pc;
                  w_mask[upd_idx] = w_rem;
                  if (w_free_found) begin
                     w_st[w_free_idx]   = ST_READY;
                     w_pc[w_free_idx]   = upd_taken_pc;
                     w_mask[w_free_idx] = w_tk;
                  end
               end
            end else begin
               w_pc[upd_idx] = upd_pc;
               w_st[upd_idx] = upd_stall ? ST_PARKED : ST_READY;
            end
         end

         if (w_sel_fire) begin
            w_sel_valid = w_pick_found;
            if (w_pick_found) begin
               w_sel_idx          = w_pick_idx;
               w_sel_pc           = r_pc[w_pick_idx];
               w_sel_mask         = r_mask[w_pick_idx];
               w_st[w_pick_idx]   = ST_ISSUED;
               w_rr               = w_pick_idx;
            end
         end

`ifdef SPLIT_TABLE_MERGE_EN
         if (w_sel_fire && w_pick_found)
            w_excl[w_pick_idx] = 1'b1;
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            for (int unsigned j = i + 1; j < ENTRY_NUM; j++) begin
               if (!w_merged && (r_st[i] == ST_READY) && (r_st[j] == ST_READY) &&
                   (r_pc[i] == r_pc[j]) && !w_excl[i] && !w_excl[j]) begin
                  w_merged  = 1'b1;
                  w_mask[i] = r_mask[i] | r_mask[j];
                  w_st[j]   = ST_FREE;
               end
            end
         end
`endif
      end

      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
         if (w_st[i] == ST_FREE) w_split_ready = 1'b1;
         else                    w_empty       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            r_st[i]   <= ST_FREE;
            r_pc[i]   <= '0;
            r_mask[i] <= '0;
         end
         r_rr          <= '0;
         r_sel_valid   <= 1'b0;
         r_sel_idx     <= '0;
         r_sel_pc      <= '0;
         r_sel_mask    <= '0;
         r_split_ready <= 1'b1;
         r_empty       <= 1'b1;
      end else begin
         r_st          <= w_st;
         r_pc          <= w_pc;
         r_mask        <= w_mask;
         r_rr          <= w_rr;
         r_sel_valid   <= w_sel_valid;
         r_sel_idx     <= w_sel_idx;
         r_sel_pc      <= w_sel_pc;
         r_sel_mask    <= w_sel_mask;
         r_split_ready <= w_split_ready;
         r_empty       <= w_empty;
      end
   end

   // A real split needs a free slot; otherwise the taken threads are lost.
   a_split_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (rdy && w_alloc) |-> w_free_found);

   assign sel_valid   = r_sel_valid;
   assign sel_idx     = r_sel_idx;
   assign sel_pc      = r_sel_pc;
   assign sel_mask    = r_sel_mask;
   assign split_ready = r_split_ready;
   assign empty       = r_empty;

endmodule
